// File: rtl/cpu_pkg.sv
// Shared definitions for the scalar+vector CPU: control-word bit positions,
// ALU opcode enums and datapath widths.
package cpu_pkg;

  localparam int XLEN      = 16;
  localparam int VLEN      = 128;
  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 20;
  localparam int ALU_OP_W  = 5;

  localparam int CW_WRE        = 19;
  localparam int CW_VWRE       = 18;
  localparam int CW_WMEM_A     = 17;
  localparam int CW_WMEM_B     = 16;
  localparam int CW_SEL_WB_HI  = 15;
  localparam int CW_SEL_WB_LO  = 14;
  localparam int CW_SEL_WBV_HI = 13;
  localparam int CW_SEL_WBV_LO = 12;
  localparam int CW_ALUOP_HI   = 11;
  localparam int CW_ALUOP_LO   = 7;
  localparam int CW_VALUOP_HI  = 6;
  localparam int CW_VALUOP_LO  = 2;
  localparam int CW_LOAD       = 1;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ZERO  = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_MUL   = 5'd3,
    ALU_AND   = 5'd4,
    ALU_OR    = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_SLL   = 5'd7,
    ALU_SRL   = 5'd8,
    ALU_PASSA = 5'd9,
    ALU_PASSB = 5'd10,
    ALU_SLTU  = 5'd11
  } alu_op_e;

  typedef enum logic [ALU_OP_W-1:0] {
    VALU_ZERO  = 5'd0,
    VALU_ADD   = 5'd1,
    VALU_SUB   = 5'd2,
    VALU_XOR   = 5'd3,
    VALU_AND   = 5'd4,
    VALU_OR    = 5'd5,
    VALU_SLL   = 5'd6,
    VALU_SRL   = 5'd7,
    VALU_ROTL  = 5'd8,
    VALU_ROTR  = 5'd9,
    VALU_PASSA = 5'd10,
    VALU_PASSB = 5'd11
  } valu_op_e;

endpackage

// File: rtl/valu_lane8.sv
// One 8-bit vector lane operator; lanes are fully independent (no carries).
module valu_lane8
  import cpu_pkg::*;
(
  input  logic [ALU_OP_W-1:0] op,
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  output logic [7:0]          y
);

  logic [2:0] sh;
  assign sh = b[2:0];

  always_comb begin
    y = 8'd0;
    case (op)
      VALU_ADD:   y = a + b;
      VALU_SUB:   y = a - b;
      VALU_XOR:   y = a ^ b;
      VALU_AND:   y = a & b;
      VALU_OR:    y = a | b;
      VALU_SLL:   y = a << sh;
      VALU_SRL:   y = a >> sh;
      // A shift by 8 clears an 8-bit value, so sh == 0 degenerates to a plain copy.
      VALU_ROTL:  y = (a << sh) | (a >> (4'd8 - {1'b0, sh}));
      VALU_ROTR:  y = (a >> sh) | (a << (4'd8 - {1'b0, sh}));
      VALU_PASSA: y = a;
      VALU_PASSB: y = b;
      default:    y = 8'd0;
    endcase
  end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode/Execute pipeline register with the execute-stage scalar ALU and
// LANES-wide vector ALU. Vector datapath is built only when VECTOR_ALU_EN is defined.
module decode_execute_stage
  import cpu_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CTRL_W-1:0]      nop_mux_output_in,
  input  logic [XLEN-1:0]        srcA_in,
  input  logic [XLEN-1:0]        srcB_in,
  input  logic [8*LANES-1:0]     srcA_vector_in,
  input  logic [8*LANES-1:0]     srcB_vector_in,
  input  logic [REG_IDX_W-1:0]   rs1_decode,
  input  logic [REG_IDX_W-1:0]   rs2_decode,
  input  logic [REG_IDX_W-1:0]   rd_decode,
  input  logic [XLEN-1:0]        alu_src_A,
  input  logic [XLEN-1:0]        alu_src_B,
  output logic                   wre_execute,
  output logic                   vector_wre_execute,
  output logic                   write_memory_enable_a_execute,
  output logic                   write_memory_enable_b_execute,
  output logic [1:0]             select_writeback_data_mux_execute,
  output logic [1:0]             select_writeback_vector_data_mux_execute,
  output logic [ALU_OP_W-1:0]    aluOp_execute,
  output logic [ALU_OP_W-1:0]    aluVectorOp_execute,
  output logic                   load_instruction,
  output logic [XLEN-1:0]        srcA_out,
  output logic [XLEN-1:0]        srcB_out,
  output logic [8*LANES-1:0]     srcA_vector_out,
  output logic [8*LANES-1:0]     srcB_vector_out,
  output logic [REG_IDX_W-1:0]   rs1_execute,
  output logic [REG_IDX_W-1:0]   rs2_execute,
  output logic [REG_IDX_W-1:0]   rd_execute,
  output logic [XLEN-1:0]        alu_result_execute,
  output logic [8*LANES-1:0]     alu_vector_result_execute
);

  localparam int VW = 8 * LANES;

  // Bit 0 of the control word is reserved and deliberately not stored.
  logic [CTRL_W-1:1]    ctrl_p1;
  logic [XLEN-1:0]      srca_p1, srcb_p1;
  logic [REG_IDX_W-1:0] rs1_p1, rs2_p1, rd_p1;

  // ---- Decode -> Execute boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_p1 <= '0;
      srca_p1 <= '0;
      srcb_p1 <= '0;
      rs1_p1  <= '0;
      rs2_p1  <= '0;
      rd_p1   <= '0;
    end else begin
      ctrl_p1 <= nop_mux_output_in[CTRL_W-1:1];
      srca_p1 <= srcA_in;
      srcb_p1 <= srcB_in;
      rs1_p1  <= rs1_decode;
      rs2_p1  <= rs2_decode;
      rd_p1   <= rd_decode;
    end
  end

  assign wre_execute                              = ctrl_p1[CW_WRE];
  assign write_memory_enable_a_execute            = ctrl_p1[CW_WMEM_A];
  assign select_writeback_data_mux_execute        = ctrl_p1[CW_SEL_WB_HI:CW_SEL_WB_LO];
  assign select_writeback_vector_data_mux_execute = ctrl_p1[CW_SEL_WBV_HI:CW_SEL_WBV_LO];
  assign aluOp_execute                            = ctrl_p1[CW_ALUOP_HI:CW_ALUOP_LO];
  assign load_instruction                         = ctrl_p1[CW_LOAD];
  assign srcA_out                                 = srca_p1;
  assign srcB_out                                 = srcb_p1;
  assign rs1_execute                              = rs1_p1;
  assign rs2_execute                              = rs2_p1;
  assign rd_execute                               = rd_p1;

  // ---- Execute: scalar ALU on the forwarded operands (low byte only) ----
  logic [XLEN-1:0] a16, b16;
  assign a16 = {8'd0, alu_src_A[7:0]};
  assign b16 = {8'd0, alu_src_B[7:0]};

  always_comb begin
    alu_result_execute = '0;
    case (aluOp_execute)
      ALU_ADD:   alu_result_execute = a16 + b16;
      ALU_SUB:   alu_result_execute = a16 - b16;
      ALU_MUL:   alu_result_execute = a16 * b16;
      ALU_AND:   alu_result_execute = a16 & b16;
      ALU_OR:    alu_result_execute = a16 | b16;
      ALU_XOR:   alu_result_execute = a16 ^ b16;
      ALU_SLL:   alu_result_execute = a16 << b16[2:0];
      ALU_SRL:   alu_result_execute = a16 >> b16[2:0];
      ALU_PASSA: alu_result_execute = a16;
      ALU_PASSB: alu_result_execute = b16;
      ALU_SLTU:  alu_result_execute = {15'd0, (a16 < b16)};
      default:   alu_result_execute = '0;
    endcase
  end

`ifdef VECTOR_ALU_EN
  logic [VW-1:0] srca_vec_p1, srcb_vec_p1;
  logic [VW-1:0] vres;

  always_ff @(posedge clk) begin
    if (reset) begin
      srca_vec_p1 <= '0;
      srcb_vec_p1 <= '0;
    end else begin
      srca_vec_p1 <= srcA_vector_in;
      srcb_vec_p1 <= srcB_vector_in;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    valu_lane8 u_lane (
      .op (ctrl_p1[CW_VALUOP_HI:CW_VALUOP_LO]),
      .a  (srca_vec_p1[8*i +: 8]),
      .b  (srcb_vec_p1[8*i +: 8]),
      .y  (vres[8*i +: 8])
    );
  end

  assign vector_wre_execute            = ctrl_p1[CW_VWRE];
  assign write_memory_enable_b_execute = ctrl_p1[CW_WMEM_B];
  assign aluVectorOp_execute           = ctrl_p1[CW_VALUOP_HI:CW_VALUOP_LO];
  assign srcA_vector_out               = srca_vec_p1;
  assign srcB_vector_out               = srcb_vec_p1;
  assign alu_vector_result_execute     = vres;

  logic unused_bits;
  assign unused_bits = ^{nop_mux_output_in[0], alu_src_A[15:8], alu_src_B[15:8]};
`else
  // Scalar-only build: vector side reads as permanently idle.
  assign vector_wre_execute            = 1'b0;
  assign write_memory_enable_b_execute = 1'b0;
  assign aluVectorOp_execute           = ctrl_p1[CW_VALUOP_HI:CW_VALUOP_LO];
  assign srcA_vector_out               = '0;
  assign srcB_vector_out               = '0;
  assign alu_vector_result_execute     = '0;

  logic unused_bits;
  assign unused_bits = ^{nop_mux_output_in[0], alu_src_A[15:8], alu_src_B[15:8],
                         srcA_vector_in, srcB_vector_in,
                         ctrl_p1[CW_VWRE], ctrl_p1[CW_WMEM_B]};
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Directed + random scoreboard bench for decode_execute_stage (honours VECTOR_ALU_EN).
module tb_decode_execute_stage;

  localparam int LANES = 16;
  localparam int VW    = 8 * LANES;
`ifdef VECTOR_ALU_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [19:0]   nop_mux_output_in;
  logic [15:0]   srcA_in, srcB_in, alu_src_A, alu_src_B;
  logic [VW-1:0] srcA_vector_in, srcB_vector_in;
  logic [4:0]    rs1_decode, rs2_decode, rd_decode;
  logic          wre_execute, vector_wre_execute;
  logic          write_memory_enable_a_execute, write_memory_enable_b_execute;
  logic [1:0]    select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute;
  logic [4:0]    aluOp_execute, aluVectorOp_execute;
  logic          load_instruction;
  logic [15:0]   srcA_out, srcB_out, alu_result_execute;
  logic [VW-1:0] srcA_vector_out, srcB_vector_out, alu_vector_result_execute;
  logic [4:0]    rs1_execute, rs2_execute, rd_execute;

  decode_execute_stage #(.LANES(LANES)) dut (
    .clk(clk), .reset(reset),
    .nop_mux_output_in(nop_mux_output_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcA_vector_in(srcA_vector_in), .srcB_vector_in(srcB_vector_in),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
    .alu_src_A(alu_src_A), .alu_src_B(alu_src_B),
    .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
    .write_memory_enable_a_execute(write_memory_enable_a_execute),
    .write_memory_enable_b_execute(write_memory_enable_b_execute),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .select_writeback_vector_data_mux_execute(select_writeback_vector_data_mux_execute),
    .aluOp_execute(aluOp_execute), .aluVectorOp_execute(aluVectorOp_execute),
    .load_instruction(load_instruction),
    .srcA_out(srcA_out), .srcB_out(srcB_out),
    .srcA_vector_out(srcA_vector_out), .srcB_vector_out(srcB_vector_out),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .alu_result_execute(alu_result_execute),
    .alu_vector_result_execute(alu_vector_result_execute)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wre, vwre, wma, wmb, load;
    logic [1:0]    selwb, selwbv;
    logic [4:0]    aluop, valuop, rs1, rs2, rd;
    logic [15:0]   sa, sb, res;
    logic [VW-1:0] va, vb, vres;
  } exp_t;

  exp_t sb_q[$];
  int compared   = 0;
  int mismatched = 0;

  function automatic logic [15:0] salu_model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r  = 0;
    if      (op == 5'd1)  r = ai + bi;
    else if (op == 5'd2)  r = ai - bi;
    else if (op == 5'd3)  r = ai * bi;
    else if (op == 5'd4)  r = ai & bi;
    else if (op == 5'd5)  r = ai | bi;
    else if (op == 5'd6)  r = ai ^ bi;
    else if (op == 5'd7)  r = ai << (bi % 8);
    else if (op == 5'd8)  r = ai >> (bi % 8);
    else if (op == 5'd9)  r = ai;
    else if (op == 5'd10) r = bi;
    else if (op == 5'd11) r = (ai < bi) ? 1 : 0;
    return r[15:0];
  endfunction

  function automatic logic [7:0] vlane_model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int s  = bi % 8;
    int r  = 0;
    if      (op == 5'd1)  r = ai + bi;
    else if (op == 5'd2)  r = ai - bi;
    else if (op == 5'd3)  r = ai ^ bi;
    else if (op == 5'd4)  r = ai & bi;
    else if (op == 5'd5)  r = ai | bi;
    else if (op == 5'd6)  r = ai << s;
    else if (op == 5'd7)  r = ai >> s;
    else if (op == 5'd8)  r = (ai << s) | (ai >> (8 - s));
    else if (op == 5'd9)  r = (ai >> s) | (ai << (8 - s));
    else if (op == 5'd10) r = ai;
    else if (op == 5'd11) r = bi;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic rst_i, input logic [19:0] cw,
                      input logic [15:0] sa, input logic [15:0] sb,
                      input logic [15:0] fa, input logic [15:0] fb,
                      input logic [VW-1:0] va, input logic [VW-1:0] vb,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdi);
    exp_t e;
    exp_t g;
    reset = rst_i; nop_mux_output_in = cw;
    srcA_in = sa; srcB_in = sb; alu_src_A = fa; alu_src_B = fb;
    srcA_vector_in = va; srcB_vector_in = vb;
    rs1_decode = r1; rs2_decode = r2; rd_decode = rdi;

    e.wre    = rst_i ? 1'b0 : cw[19];
    e.vwre   = (rst_i || !VEC_EN) ? 1'b0 : cw[18];
    e.wma    = rst_i ? 1'b0 : cw[17];
    e.wmb    = (rst_i || !VEC_EN) ? 1'b0 : cw[16];
    e.selwb  = rst_i ? 2'd0 : cw[15:14];
    e.selwbv = rst_i ? 2'd0 : cw[13:12];
    e.aluop  = rst_i ? 5'd0 : cw[11:7];
    e.valuop = rst_i ? 5'd0 : cw[6:2];
    e.load   = rst_i ? 1'b0 : cw[1];
    e.sa     = rst_i ? 16'd0 : sa;
    e.sb     = rst_i ? 16'd0 : sb;
    e.rs1    = rst_i ? 5'd0 : r1;
    e.rs2    = rst_i ? 5'd0 : r2;
    e.rd     = rst_i ? 5'd0 : rdi;
    e.va     = (rst_i || !VEC_EN) ? '0 : va;
    e.vb     = (rst_i || !VEC_EN) ? '0 : vb;
    e.res    = salu_model(e.aluop, fa[7:0], fb[7:0]);
    e.vres   = '0;
    for (int i = 0; i < LANES; i++)
      e.vres[8*i +: 8] = vlane_model(e.valuop, e.va[8*i +: 8], e.vb[8*i +: 8]);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    chk("wre",    {127'd0, wre_execute}, {127'd0, g.wre});
    chk("vwre",   {127'd0, vector_wre_execute}, {127'd0, g.vwre});
    chk("wmem_a", {127'd0, write_memory_enable_a_execute}, {127'd0, g.wma});
    chk("wmem_b", {127'd0, write_memory_enable_b_execute}, {127'd0, g.wmb});
    chk("sel_wb", {126'd0, select_writeback_data_mux_execute}, {126'd0, g.selwb});
    chk("sel_wbv",{126'd0, select_writeback_vector_data_mux_execute}, {126'd0, g.selwbv});
    chk("aluop",  {123'd0, aluOp_execute}, {123'd0, g.aluop});
    chk("valuop", {123'd0, aluVectorOp_execute}, {123'd0, g.valuop});
    chk("load",   {127'd0, load_instruction}, {127'd0, g.load});
    chk("srcA",   {112'd0, srcA_out}, {112'd0, g.sa});
    chk("srcB",   {112'd0, srcB_out}, {112'd0, g.sb});
    chk("rs1",    {123'd0, rs1_execute}, {123'd0, g.rs1});
    chk("rs2",    {123'd0, rs2_execute}, {123'd0, g.rs2});
    chk("rd",     {123'd0, rd_execute}, {123'd0, g.rd});
    chk("vecA",   srcA_vector_out, g.va);
    chk("vecB",   srcB_vector_out, g.vb);
    chk("alu",    {112'd0, alu_result_execute}, {112'd0, g.res});
    chk("valu",   alu_vector_result_execute, g.vres);
  endtask

  initial begin
    logic [VW-1:0] rv_a, rv_b;
    logic [19:0]   rcw;
    // Reset held for two edges with busy inputs
    step(1'b1, 20'hFFFFF, 16'hBEEF, 16'hCAFE, 16'h0011, 16'h0022, {16{8'h5A}}, {16{8'hA5}}, 5'd7, 5'd8, 5'd9);
    step(1'b1, 20'hFFFFF, 16'hBEEF, 16'hCAFE, 16'h0011, 16'h0022, {16{8'h5A}}, {16{8'hA5}}, 5'd7, 5'd8, 5'd9);
    // First normal edge: wre with ADD
    step(1'b0, 20'h80000 | (20'd1 << 7), 16'd0, 16'd0, 16'h0002, 16'h0003, '0, '0, 5'd0, 5'd0, 5'd1);
    // Scalar ADD / SUB / MUL with junk upper operand bits
    step(1'b0, 20'd1 << 7, 16'd0, 16'd0, 16'hABFF, 16'hAB01, '0, '0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 20'd2 << 7, 16'd0, 16'd0, 16'hAB03, 16'hAB05, '0, '0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 20'd3 << 7, 16'd0, 16'd0, 16'hABFF, 16'hABFF, '0, '0, 5'd0, 5'd0, 5'd0);
    // Vector ADD without inter-lane carry; vector ROTL
    step(1'b0, (20'd1 << 2) | 20'h40000, 16'd0, 16'd0, 16'd0, 16'd0, {16{8'hFF}}, {16{8'h01}}, 5'd0, 5'd0, 5'd0);
    step(1'b0, 20'd8 << 2, 16'd0, 16'd0, 16'd0, 16'd0, {16{8'h81}}, {16{8'h01}}, 5'd0, 5'd0, 5'd0);
    // Pipeline capture
    step(1'b0, (20'd1 << 17) | (20'd1 << 1), 16'h1234, 16'h5678, 16'd0, 16'd0, '0, '0, 5'd3, 5'd4, 5'd5);
    // Bubble and undefined opcodes
    step(1'b0, 20'h00000, 16'h1111, 16'h2222, 16'h00F0, 16'h000F, {16{8'h33}}, {16{8'h44}}, 5'd1, 5'd2, 5'd3);
    step(1'b0, (20'd31 << 7) | (20'd31 << 2) | 20'd1, 16'h1111, 16'h2222, 16'h00F0, 16'h000F, {16{8'h33}}, {16{8'h44}}, 5'd1, 5'd2, 5'd3);
    // Remaining scalar ops spot checks
    step(1'b0, 20'd7 << 7, 16'd0, 16'd0, 16'h00FF, 16'h0007, '0, '0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 20'd11 << 7, 16'd0, 16'd0, 16'h0003, 16'h0005, '0, '0, 5'd0, 5'd0, 5'd0);
    step(1'b0, (20'd9 << 2) | (20'd3 << 12) | (20'd2 << 14), 16'd0, 16'd0, 16'd0, 16'd0, {16{8'h81}}, {16{8'h03}}, 5'd0, 5'd0, 5'd0);
    // Reset mid-stream discards the captured instruction
    step(1'b1, 20'hFFFFE, 16'h9999, 16'h8888, 16'h0001, 16'h0001, {16{8'h77}}, {16{8'h66}}, 5'd31, 5'd30, 5'd29);
    // Random traffic
    for (int n = 0; n < 40; n++) begin
      rcw  = 20'($urandom);
      rv_a = {$urandom, $urandom, $urandom, $urandom};
      rv_b = {$urandom, $urandom, $urandom, $urandom};
      step(1'b0, rcw, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           rv_a, rv_b, 5'($urandom), 5'($urandom), 5'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
